// File: rtl/alu_sequencer.sv
// Issue-side controller for a combinational 16-bit ALU: register file, operand issue,
// writeback and architectural {N,Z,V,C}. Optional carry support via macro ALU_CARRY_EN.
module alu_sequencer #(
  parameter int NREGS = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_ra,
  input  logic [1:0]       instr_rb,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_ccr,
  output logic [3:0]       ccr,
  output logic             done,
  output logic             illegal,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WB} state_t;

  state_t           state;
  logic [WIDTH-1:0] rf [NREGS];
  logic [3:0]       op_q;
  logic [1:0]       rd_q;
  logic [1:0]       ra_q;
  logic [1:0]       rb_q;
  logic [1:0]       ccr_nz;
  logic             carry;

  // Handshake: an instruction is accepted on a rising edge where instr_valid
  // and instr_ready are both high; instr_ready is high only in IDLE outside reset.
  assign instr_ready = (state == IDLE) && !reset;
  assign dbg_data    = rf[dbg_sel];
  assign dbg_state   = state;
  assign ccr         = {ccr_nz, 1'b0, carry};

  // The ALU's V/C outputs are not architectural here.
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_ccr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      ccr_nz  <= '0;
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (ld_en) rf[ld_addr] <= ld_data;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            ra_q  <= instr_ra;
            rb_q  <= instr_rb;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          alu_op <= op_q;
          alu_a  <= rf[ra_q];
          alu_b  <= rf[rb_q];
          state  <= EXEC;
        end
        EXEC: begin
          done <= 1'b1;
          // Placed after the load above so a same-edge writeback to rd wins.
          if (op_q <= 4'd10) begin
            rf[rd_q] <= alu_result;
            ccr_nz   <= alu_ccr[3:2];
          end else if (op_q >= 4'd13) begin
            illegal <= 1'b1;
          end
          state <= WB;
        end
        WB: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CARRY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
    end else if (state == EXEC) begin
      if (op_q == 4'd11) carry <= 1'b0;
      else if (op_q == 4'd12) carry <= 1'b1;
    end
  end
`else
  assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, transaction-level reference model,
// per-cycle comparison plus directed literal checks and randomized traffic.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [1:0]  instr_rd, instr_ra, instr_rb;
  logic        ld_en;
  logic [1:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ccr;
  logic [3:0]  ccr;
  logic        done, illegal;
  logic [1:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_ccr(alu_ccr),
    .ccr(ccr), .done(done), .illegal(illegal),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- behavioural ALU ----------------
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a;
      4'd1:    return b;
      4'd2:    return ~a;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a + b;
      4'd7:    return a - b;
      4'd8:    return a << 1;
      4'd9:    return a >> 1;
      4'd10:   return -a;
      default: return a ^ 16'h5A5A;
    endcase
  endfunction

  // V/C from the ALU are driven as junk; the sequencer must ignore them.
  always_comb begin
    alu_result = alu_fn(alu_op, alu_a, alu_b);
    alu_ccr    = {alu_result[15], (alu_result == 16'h0), 2'b11};
  end

  // ---------------- reference model ----------------
  bit          m_valid = 0;
  logic [15:0] m_rf [4];
  logic [3:0]  m_ccr, m_alu_op, m_op;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_rd, m_ra, m_rb;
  logic        m_done, m_ill;
  int          m_age = -1;  // edges since acceptance, -1 when no instruction in flight

  always @(posedge clk) begin
    logic [15:0] old_rf [4];
    logic [15:0] r;
    old_rf = m_rf;
    if (reset) begin
      m_valid = 1;
      for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;
      m_ccr = 4'h0; m_alu_op = 4'h0; m_a = 16'h0; m_b = 16'h0;
      m_done = 0; m_ill = 0; m_age = -1;
    end else begin
      if (ld_en) m_rf[ld_addr] = ld_data;
      if (m_age == -1) begin
        if (instr_valid) begin
          m_op = instr_op; m_rd = instr_rd; m_ra = instr_ra; m_rb = instr_rb;
          m_age = 0;
        end
      end else if (m_age == 0) begin
        m_alu_op = m_op; m_a = old_rf[m_ra]; m_b = old_rf[m_rb];
        m_age = 1;
      end else if (m_age == 1) begin
        r = alu_fn(m_op, m_a, m_b);
        m_done = 1;
        if (m_op <= 4'd10) begin
          m_rf[m_rd] = r;
          m_ccr = {r[15], (r == 16'h0), 1'b0, m_ccr[0]};
        end else if (m_op >= 4'd13) begin
          m_ill = 1;
        end
`ifdef ALU_CARRY_EN
        else if (m_op == 4'd11) m_ccr[0] = 1'b0;
        else if (m_op == 4'd12) m_ccr[0] = 1'b1;
`endif
        m_age = 2;
      end else begin
        m_done = 0; m_ill = 0; m_age = -1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("instr_ready", 32'(instr_ready), 32'(!reset && m_age == -1));
      check("done",        32'(done),        32'(m_done));
      check("illegal",     32'(illegal),     32'(m_ill));
      check("ccr",         32'(ccr),         32'(m_ccr));
      check("alu_op",      32'(alu_op),      32'(m_alu_op));
      check("alu_a",       32'(alu_a),       32'(m_a));
      check("alu_b",       32'(alu_b),       32'(m_b));
      check("dbg_data",    32'(dbg_data),    32'(m_rf[dbg_sel]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [15:0] v);
    dbg_sel = a;
    #1;
    v = dbg_data;
  endtask

  // Issue one instruction; optionally load ld_d into ld_a on the EXEC edge.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input bit inj, input logic [1:0] ld_a,
                       input logic [15:0] ld_d, output int lat, output logic ill_seen);
    int budget;
    instr_valid = 1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    budget = 0;
    while (!instr_ready && budget < 10) begin tick(); budget++; end
    tick();
    instr_valid = 0;
    lat = 1;
    ill_seen = 0;
    while (!done && lat < 8) begin
      if (inj && lat == 2) begin ld_en = 1; ld_addr = ld_a; ld_data = ld_d; end
      tick();
      ld_en = 0;
      lat++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    ill_seen = illegal;
    tick();
    check("ready_after_wb", 32'(instr_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] v;
  logic [3:0]  c_set, c_clr;
  int          lat;
  logic        ill;
  int          acc [$];

  initial begin
    reset = 1; instr_valid = 0; instr_op = 0; instr_rd = 0; instr_ra = 0; instr_rb = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0; dbg_sel = 0;
    #1;
    repeat (3) tick();
    check("ready_in_reset", 32'(instr_ready), 32'd0);
    check("ccr_reset", 32'(ccr), 32'h0);
    reset = 0;
    tick();

    // and: 0x00F0 & 0x0FF0
    load(2'd0, 16'h00F0);
    load(2'd1, 16'h0FF0);
    issue(4'd3, 2'd2, 2'd0, 2'd1, 0, 2'd0, 16'h0, lat, ill);
    check("and_latency", 32'(lat), 32'd3);
    read_reg(2'd2, v);
    check("and_rf2", 32'(v), 32'h00F0);
    check("and_ccr", 32'(ccr), 32'h0);

    // nop_a zero then negative
    load(2'd0, 16'h0000);
    issue(4'd0, 2'd3, 2'd0, 2'd0, 0, 2'd0, 16'h0, lat, ill);
    read_reg(2'd3, v);
    check("nop_zero_rf3", 32'(v), 32'h0000);
    check("nop_zero_ccr", 32'(ccr), 32'h4);
    load(2'd0, 16'h8001);
    issue(4'd0, 2'd3, 2'd0, 2'd0, 0, 2'd0, 16'h0, lat, ill);
    read_reg(2'd3, v);
    check("nop_neg_rf3", 32'(v), 32'h8001);
    check("nop_neg_ccr", 32'(ccr), 32'h8);

    // set_c / clr_c
`ifdef ALU_CARRY_EN
    c_set = 4'h9; c_clr = 4'h8;
`else
    c_set = 4'h8; c_clr = 4'h8;
`endif
    issue(4'd12, 2'd0, 2'd1, 2'd1, 0, 2'd0, 16'h0, lat, ill);
    check("set_c_ccr", 32'(ccr), 32'(c_set));
    check("set_c_illegal", 32'(ill), 32'd0);
    read_reg(2'd0, v);
    check("set_c_rf0", 32'(v), 32'h8001);
    issue(4'd11, 2'd0, 2'd1, 2'd1, 0, 2'd0, 16'h0, lat, ill);
    check("clr_c_ccr", 32'(ccr), 32'(c_clr));
    check("clr_c_latency", 32'(lat), 32'd3);

    // illegal opcode
    issue(4'd14, 2'd1, 2'd0, 2'd0, 0, 2'd0, 16'h0, lat, ill);
    check("illegal_pulse", 32'(ill), 32'd1);
    check("illegal_ccr", 32'(ccr), 32'h8);
    read_reg(2'd1, v);
    check("illegal_rf1", 32'(v), 32'h0FF0);

    // writeback wins over same-edge load: not_a of 0x00FF
    load(2'd1, 16'h00FF);
    issue(4'd2, 2'd1, 2'd1, 2'd0, 1, 2'd1, 16'h1234, lat, ill);
    read_reg(2'd1, v);
    check("wb_wins_rf1", 32'(v), 32'hFF00);
    check("wb_wins_ccr", 32'(ccr), 32'(c_clr | 4'h8));

    // valid held high: acceptances 4 cycles apart
    instr_valid = 1; instr_op = 4'd6; instr_rd = 2'd0; instr_ra = 2'd1; instr_rb = 2'd2;
    for (int i = 0; i < 17; i++) begin
      if (instr_ready) acc.push_back(cyc);
      tick();
    end
    instr_valid = 0;
    check("b2b_count", 32'(acc.size() >= 4), 32'd1);
    for (int i = 1; i < acc.size(); i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd4);
    repeat (4) tick();

    // reset during EXEC aborts the instruction
    load(2'd3, 16'h7777);
    instr_valid = 1; instr_op = 4'd0; instr_rd = 2'd2; instr_ra = 2'd3; instr_rb = 2'd3;
    while (!instr_ready) tick();
    tick();
    instr_valid = 0;
    tick();
    reset = 1;
    tick();
    check("abort_done", 32'(done), 32'd0);
    tick();
    reset = 0;
    tick();
    check("abort_done_after", 32'(done), 32'd0);
    read_reg(2'd2, v);
    check("abort_rf2", 32'(v), 32'h0);
    check("abort_ccr", 32'(ccr), 32'h0);
    check("abort_alu_a", 32'(alu_a), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr_op    = 4'($urandom_range(0, 15));
      instr_rd    = 2'($urandom_range(0, 3));
      instr_ra    = 2'($urandom_range(0, 3));
      instr_rb    = 2'($urandom_range(0, 3));
      ld_en       = ($urandom_range(0, 3) == 0);
      ld_addr     = 2'($urandom_range(0, 3));
      ld_data     = 16'($urandom_range(0, 65535));
      dbg_sel     = 2'($urandom_range(0, 3));
      reset       = ($urandom_range(0, 199) == 0);
      tick();
    end
    instr_valid = 0; ld_en = 0; reset = 0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
